ddr_pod_loader: RTL and testbench

//   DMA engine upstream of one pod memory's DDR off-chip port. Accepts a copy command, issues

---
 rtl/ddr_pod_loader.sv | 161 ++++++++++++++++
 tb/tb_ddr_pod_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_pod_loader.sv
// ddr_pod_loader
//   DMA engine in front of one pod memory's off-chip write port. A copy command
//   (src, dst, len) produces len sequential reads on one DDR channel. Each read
//   returns after a fixed RD_LAT cycles and is written to the pod memory one
//   cycle later, at dst plus the number of words already written.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   ce                             clock enable, stalls read issue only
//   cmd_valid/cmd_ready            command handshake; ready only in IDLE
//   cmd_src_addr/cmd_dst_addr      DDR / pod memory start word addresses
//   cmd_len                        words to copy; 0 completes with no traffic
//   ddr_ren/ddr_raddr              DDR read strobe and address
//   ddr_rdata                      DDR return data, RD_LAT cycles after ddr_ren
//   pod_wen/pod_waddr/pod_wdata    pod memory write port
//   busy                           high whenever a command is in progress
//   done                           one-cycle completion pulse
module ddr_pod_loader #(
   parameter int ADDR_W     = 14,
   parameter int OFFCHIP_DW = 512,
   parameter int LEN_W      = 14,
   parameter int RD_LAT     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_W-1:0]     cmd_src_addr,
   input  logic [ADDR_W-1:0]     cmd_dst_addr,
   input  logic [LEN_W-1:0]      cmd_len,
   output logic                  ddr_ren,
   output logic [ADDR_W-1:0]     ddr_raddr,
   input  logic [OFFCHIP_DW-1:0] ddr_rdata,
   output logic                  pod_wen,
   output logic [ADDR_W-1:0]     pod_waddr,
   output logic [OFFCHIP_DW-1:0] pod_wdata,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t                  state_q;
   logic [LEN_W-1:0]        len_q;
   logic [LEN_W-1:0]        issued_q;
   logic [LEN_W-1:0]        written_q;
   logic [ADDR_W-1:0]       raddr_q;     // src + issued, wraps modulo 2^ADDR_W
   logic [ADDR_W-1:0]       wptr_q;      // dst + written, wraps modulo 2^ADDR_W
   logic [ADDR_W-1:0]       pod_waddr_q;
   logic [OFFCHIP_DW-1:0]   pod_wdata_q;
   logic                    pod_wen_q;
   logic                    busy_q;
   logic                    done_q;
   logic [RD_LAT-1:0]       vld_q;       // bit i set: a read issued i+1 cycles ago
   logic [RD_LAT-1:0]       vld_d;
   logic                    issue;

   // The strobe is qualified by ce in the same cycle so a stall suppresses the
   // read immediately; the address itself comes straight from a register.
   assign issue     = (state_q == S_ISSUE) && ce;
   assign ddr_ren   = issue;
   assign ddr_raddr = raddr_q;
   assign cmd_ready = (state_q == S_IDLE);
   assign pod_wen   = pod_wen_q;
   assign pod_waddr = pod_waddr_q;
   assign pod_wdata = pod_wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;

   // The in-flight tracker shifts every cycle regardless of ce: DDR latency is
   // external, so a return must be captured even while issue is stalled.
   always_comb begin
      vld_d    = '0;
      vld_d[0] = issue;
      for (int i = 1; i < RD_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         issued_q    <= '0;
         written_q   <= '0;
         raddr_q     <= '0;
         wptr_q      <= '0;
         pod_waddr_q <= '0;
         pod_wdata_q <= '0;
         pod_wen_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         vld_q       <= '0;
      end else begin
         vld_q     <= vld_d;
         done_q    <= 1'b0;

         // Return path: data sampled in the cycle its valid bit leaves the
         // tracker, written to the pod memory in the following cycle.
         pod_wen_q <= vld_q[RD_LAT-1];
         if (vld_q[RD_LAT-1]) begin
            pod_wdata_q <= ddr_rdata;
            pod_waddr_q <= wptr_q;
            wptr_q      <= wptr_q + ADDR_ONE;
            written_q   <= written_q + LEN_ONE;
         end

         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  len_q     <= cmd_len;
                  raddr_q   <= cmd_src_addr;
                  wptr_q    <= cmd_dst_addr;
                  issued_q  <= '0;
                  written_q <= '0;
                  busy_q    <= 1'b1;
                  if (cmd_len == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (ce) begin
                  raddr_q  <= raddr_q + ADDR_ONE;
                  issued_q <= issued_q + LEN_ONE;
                  if (issued_q == len_q - LEN_ONE) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (written_q == len_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_pod_loader.sv
// Bench for ddr_pod_loader: a DDR fixture returns f(address, salt) RD_LAT
// cycles after each strobe; a reference model derives every expected read,
// write and completion cycle from the recorded ce sequence.
module tb_ddr_pod_loader;
   localparam int ADDR_W = 14;
   localparam int DW     = 512;
   localparam int LEN_W  = 14;
   localparam int RD_LAT = 4;

   logic              clk = 1'b0;
   logic              rst, ce, cmd_valid, cmd_ready;
   logic [ADDR_W-1:0] cmd_src_addr, cmd_dst_addr, ddr_raddr, pod_waddr;
   logic [LEN_W-1:0]  cmd_len;
   logic [DW-1:0]     ddr_rdata, pod_wdata;
   logic              ddr_ren, pod_wen, busy, done;

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   logic [31:0] salt  = 32'h0;

   ddr_pod_loader #(.ADDR_W(ADDR_W), .OFFCHIP_DW(DW), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .ce(ce),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_len(cmd_len),
      .ddr_ren(ddr_ren), .ddr_raddr(ddr_raddr), .ddr_rdata(ddr_rdata),
      .pod_wen(pod_wen), .pod_waddr(pod_waddr), .pod_wdata(pod_wdata),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] fdata(logic [ADDR_W-1:0] a, logic [31:0] s);
      logic [31:0] w;
      w = {a, 18'h0} ^ (32'h9E3779B9 * {18'h0, a}) ^ s;
      return {16{w}};
   endfunction

   // DDR fixture: fixed-latency return of the addressed word
   logic [ADDR_W-1:0] lat_a [RD_LAT];
   always @(posedge clk) begin
      lat_a[0] <= ddr_raddr;
      for (int i = 1; i < RD_LAT; i++) lat_a[i] <= lat_a[i-1];
   end
   assign ddr_rdata = fdata(lat_a[RD_LAT-1], salt);

   // Monitor: everything observed mid-cycle
   typedef struct {
      int                c;
      logic [ADDR_W-1:0] a;
      logic [DW-1:0]     d;
   } ev_t;
   ev_t rd_q[$];
   ev_t wr_q[$];
   int  done_q[$];
   int  acc_q[$];
   int  busy_cnt = 0;
   bit  ce_log[int];

   always @(negedge clk) begin
      if (!rst) begin
         ce_log[cyc] = ce;
         if (ddr_ren) rd_q.push_back('{cyc, ddr_raddr, '0});
         if (pod_wen) wr_q.push_back('{cyc, pod_waddr, pod_wdata});
         if (done) done_q.push_back(cyc);
         if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
         if (busy) busy_cnt++;
      end
   end

   task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: reads occur in the first len cycles after acceptance
   // that have ce=1; each write lands RD_LAT+1 cycles after its read; done one
   // cycle after the last write (or one cycle after acceptance for len=0).
   task automatic check_xfer(input string nm, input logic [ADDR_W-1:0] src,
                             input logic [ADDR_W-1:0] dst, input int len, input int c,
                             output int act_done, output logic [ADDR_W-1:0] last_ra,
                             output logic [ADDR_W-1:0] last_wa, output int last_wc);
      int k, last, exp_done;
      ev_t e;
      logic [ADDR_W-1:0] ra, wa;
      k = c + 1;
      last = c;
      last_ra = '0;
      last_wa = '0;
      last_wc = -1;
      for (int n = 0; n < len; n++) begin
         while (k < c + 5000 && !(ce_log.exists(k) && ce_log[k])) k++;
         ra = src + ADDR_W'(n);
         wa = dst + ADDR_W'(n);
         if (rd_q.size() == 0) chk({nm, "_rd_missing"}, 0, 1);
         else begin
            e = rd_q.pop_front();
            chk({nm, "_rd_cyc"}, e.c, k);
            chk({nm, "_rd_addr"}, e.a, ra);
            last_ra = e.a;
         end
         if (wr_q.size() == 0) chk({nm, "_wr_missing"}, 0, 1);
         else begin
            e = wr_q.pop_front();
            chk({nm, "_wr_cyc"}, e.c, k + RD_LAT + 1);
            chk({nm, "_wr_addr"}, e.a, wa);
            chk({nm, "_wr_data"}, e.d, fdata(ra, salt));
            last_wa = e.a;
            last_wc = e.c;
         end
         last = k;
         k++;
      end
      exp_done = (len == 0) ? c + 1 : last + RD_LAT + 2;
      act_done = -1;
      if (done_q.size() == 0) chk({nm, "_done_missing"}, 0, 1);
      else begin
         act_done = done_q.pop_front();
         chk({nm, "_done_cyc"}, act_done, exp_done);
      end
   endtask

   // Issue one command from IDLE and run until shortly after done (bounded).
   task automatic run_cmd(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                          input int len, input int s, input int nlo, input bit rce,
                          output int c);
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_src_addr = src;
      cmd_dst_addr = dst;
      cmd_len = LEN_W'(len);
      ce = 1'b1;
      @(negedge clk);
      c = cyc;
      chk("accept_ready", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int t = 0; t < len + RD_LAT + 300; t++) begin
         ce = rce ? ($urandom_range(0, 3) != 0) : !(cyc >= c + s && cyc < c + s + nlo);
         if (done_q.size() > 0 && cyc > done_q[0] + 1) break;
         @(posedge clk); #1;
      end
      ce = 1'b1;
   endtask

   typedef struct {
      logic [ADDR_W-1:0] src, dst;
      int                len, s, n, done_off;
      logic [ADDR_W-1:0] last_ra, last_wa;
   } vec_t;
   vec_t tab[6];

   initial begin
      int c, dn, lwc, lwc0, a0, a1, d0;
      logic [ADDR_W-1:0] lra, lwa;
      logic [ADDR_W-1:0] rs, rd;
      int rl;

      tab[0] = '{14'h0010, 14'h0100, 4, 0, 0, 10, 14'h0013, 14'h0103};
      tab[1] = '{14'h0005, 14'h0009, 0, 0, 0,  1, 14'h0000, 14'h0000};
      tab[2] = '{14'h0200, 14'h0040, 8, 3, 3, 17, 14'h0207, 14'h0047};
      tab[3] = '{14'h3FFE, 14'h3FFF, 3, 0, 0,  9, 14'h0000, 14'h0001};
      tab[4] = '{14'h1234, 14'h0000, 1, 0, 0,  7, 14'h1234, 14'h0000};
      tab[5] = '{14'h2AAA, 14'h1555, 2, 1, 2, 10, 14'h2AAB, 14'h1556};

      rst = 1'b1; ce = 1'b1; cmd_valid = 1'b0;
      cmd_src_addr = '0; cmd_dst_addr = '0; cmd_len = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", cmd_ready, 1);
      chk("rst_ren", ddr_ren, 0);
      chk("rst_wen", pod_wen, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_raddr", ddr_raddr, 0);
      chk("rst_waddr", pod_waddr, 0);
      chk("rst_wdata", pod_wdata, 0);
      rst = 1'b0;

      foreach (tab[i]) begin
         salt = $urandom;
         busy_cnt = 0;
         run_cmd(tab[i].src, tab[i].dst, tab[i].len, tab[i].s, tab[i].n, 1'b0, c);
         check_xfer($sformatf("tab%0d", i), tab[i].src, tab[i].dst, tab[i].len, c,
                    dn, lra, lwa, lwc);
         chk($sformatf("tab%0d_done_off", i), dn - c, tab[i].done_off);
         chk($sformatf("tab%0d_busy_cycles", i), busy_cnt, tab[i].done_off);
         if (tab[i].len != 0) begin
            chk($sformatf("tab%0d_last_raddr", i), lra, tab[i].last_ra);
            chk($sformatf("tab%0d_last_waddr", i), lwa, tab[i].last_wa);
         end
         chk($sformatf("tab%0d_extra_events", i), rd_q.size() + wr_q.size() + done_q.size(), 0);
      end

      // Randomized commands with random ce stalls
      for (int r = 0; r < 25; r++) begin
         salt = $urandom;
         rs = ADDR_W'($urandom);
         rd = ADDR_W'($urandom);
         rl = $urandom_range(0, 20);
         run_cmd(rs, rd, rl, 0, 0, 1'b1, c);
         check_xfer($sformatf("rnd%0d", r), rs, rd, rl, c, dn, lra, lwa, lwc);
         chk($sformatf("rnd%0d_extra_events", r), rd_q.size() + wr_q.size() + done_q.size(), 0);
      end

      // Reset in the middle of a 16-word issue phase
      salt = $urandom;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_src_addr = 14'h0500; cmd_dst_addr = 14'h0A00; cmd_len = 14'd16;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_ready", cmd_ready, 1);
      chk("midrst_ren", ddr_ren, 0);
      chk("midrst_wen", pod_wen, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_raddr", ddr_raddr, 0);
      chk("midrst_waddr", pod_waddr, 0);
      chk("midrst_wdata", pod_wdata, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      rd_q.delete(); wr_q.delete(); done_q.delete(); acc_q.delete();
      repeat (RD_LAT + 2) @(posedge clk);
      #1;
      chk("postrst_no_wen", wr_q.size(), 0);
      chk("postrst_no_ren", rd_q.size(), 0);
      run_cmd(14'h0321, 14'h0654, 5, 0, 0, 1'b0, c);
      check_xfer("postrst", 14'h0321, 14'h0654, 5, c, dn, lra, lwa, lwc);

      // cmd_valid held high: next command accepted the cycle after done
      salt = $urandom;
      acc_q.delete(); done_q.delete();
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_src_addr = 14'h0777; cmd_dst_addr = 14'h1000; cmd_len = 14'd3;
      for (int t = 0; t < 200 && acc_q.size() < 2; t++) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      for (int t = 0; t < 200 && done_q.size() < 2; t++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk("b2b_accepts", acc_q.size(), 2);
      chk("b2b_dones", done_q.size(), 2);
      if (acc_q.size() >= 2 && done_q.size() >= 1) begin
         a0 = acc_q[0];
         a1 = acc_q[1];
         d0 = done_q[0];
         chk("b2b_accept_cyc", a1, d0 + 1);
         check_xfer("b2b0", 14'h0777, 14'h1000, 3, a0, dn, lra, lwa, lwc0);
         if (wr_q.size() > 0) chk("b2b_no_overlap", wr_q[0].c > d0, 1);
         check_xfer("b2b1", 14'h0777, 14'h1000, 3, a1, dn, lra, lwa, lwc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
